// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: sends READ + 24-bit address through an external
// SPI byte engine, then streams the requested number of data bytes out.
module spi_flash_reader #(
  parameter logic [7:0] CMD_READ        = 8'h03,
  parameter int         CS_SETUP_CYCLES = 2,
  parameter int         CS_HOLD_CYCLES  = 2
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        req,
  input  logic [23:0] address,
  input  logic [7:0]  length,
  output logic        busy,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        done,
  output logic        cs_n,
  output logic        spi_start,
  output logic [7:0]  spi_data_tx,
  input  logic [7:0]  spi_data_rx,
  input  logic        spi_busy
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    CS_HOLD,
    FINISH
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(CS_SETUP_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(CS_HOLD_CYCLES - 1);

  state_t      state_r, state_s;
  logic [8:0]  idx_r, idx_s;
  logic [8:0]  term_r, term_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [23:0] addr_r, addr_s;
  logic        rx_take_s;

  logic        busy_r, byte_valid_r, done_r, cs_n_r, spi_start_r;
  logic [7:0]  byte_data_r, spi_data_tx_r;

  // Bytes 0-3 are the command and address; every later byte is a dummy clocking out data.
  function automatic logic [7:0] tx_byte(input logic [8:0] idx, input logic [23:0] addr);
    logic [7:0] b;
    case (idx)
      9'd0:    b = CMD_READ;
      9'd1:    b = addr[23:16];
      9'd2:    b = addr[15:8];
      9'd3:    b = addr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Next-state, counter and capture logic.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    term_s    = term_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    rx_take_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req && !spi_busy) begin
          state_s = CS_SETUP;
          addr_s  = address;
          term_s  = 9'd4 + ((length == 8'd0) ? 9'd256 : {1'b0, length});
          idx_s   = 9'd0;
          cnt_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      CS_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = ISSUE;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      ISSUE: begin
        state_s = WAIT_HI;
      end
      WAIT_HI: begin
        // The engine raises busy a cycle after start; waiting here keeps WAIT_LO from
        // mistaking the pre-start idle level for a finished byte.
        if (spi_busy) begin
          state_s = WAIT_LO;
        end else begin
          state_s = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!spi_busy) begin
          idx_s     = idx_r + 9'd1;
          rx_take_s = (idx_r >= 9'd4);
          if (idx_s == term_r) begin
            state_s = CS_HOLD;
          end else begin
            state_s = ISSUE;
          end
        end else begin
          state_s = WAIT_LO;
        end
      end
      CS_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          state_s = FINISH;
          cnt_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 9'd0;
      term_r        <= 9'd0;
      cnt_r         <= 4'd0;
      addr_r        <= 24'h000000;
      busy_r        <= 1'b0;
      byte_valid_r  <= 1'b0;
      byte_data_r   <= 8'h00;
      done_r        <= 1'b0;
      cs_n_r        <= 1'b1;
      spi_start_r   <= 1'b0;
      spi_data_tx_r <= 8'h00;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      term_r       <= term_s;
      cnt_r        <= cnt_s;
      addr_r       <= addr_s;
      busy_r       <= (state_s != IDLE);
      cs_n_r       <= (state_s == IDLE) || (state_s == FINISH);
      spi_start_r  <= (state_s == ISSUE);
      byte_valid_r <= rx_take_s;
      done_r       <= (state_r == FINISH);
      if (state_s == ISSUE) begin
        spi_data_tx_r <= tx_byte(idx_s, addr_s);
      end else begin
        spi_data_tx_r <= spi_data_tx_r;
      end
      if (rx_take_s) begin
        byte_data_r <= spi_data_rx;
      end else begin
        byte_data_r <= byte_data_r;
      end
    end
  end

  assign busy        = busy_r;
  assign byte_valid  = byte_valid_r;
  assign byte_data   = byte_data_r;
  assign done        = done_r;
  assign cs_n        = cs_n_r;
  assign spi_start   = spi_start_r;
  assign spi_data_tx = spi_data_tx_r;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader: behavioural SPI engine, a transaction
// table plus randomized reads, and hand-written reset / req-handshake sequences.
module tb_spi_flash_reader;

  localparam int         SETUP = 1;
  localparam int         HOLD  = 15;
  localparam logic [7:0] CMD   = 8'h03;

  logic        raw_clk;
  logic        reset;
  logic        req;
  logic [23:0] address;
  logic [7:0]  length;
  logic        busy;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        done;
  logic        cs_n;
  logic        spi_start;
  logic [7:0]  spi_data_tx;
  logic [7:0]  spi_data_rx = 8'h00;
  logic        spi_busy    = 1'b0;

  spi_flash_reader #(
    .CMD_READ       (CMD),
    .CS_SETUP_CYCLES(SETUP),
    .CS_HOLD_CYCLES (HOLD)
  ) dut (
    .raw_clk    (raw_clk),
    .reset      (reset),
    .req        (req),
    .address    (address),
    .length     (length),
    .busy       (busy),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .done       (done),
    .cs_n       (cs_n),
    .spi_start  (spi_start),
    .spi_data_tx(spi_data_tx),
    .spi_data_rx(spi_data_rx),
    .spi_busy   (spi_busy)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  int cyc = 0;
  always @(posedge raw_clk) cyc <= cyc + 1;

  // ---------------- SPI engine model ----------------
  int         eng_delay = 1;
  int         eng_hold  = 2;
  int         eng_k     = 0;
  bit         eng_active = 1'b0;
  int         eng_rd    = 0;
  int         n_start   = 0;
  int         dup_start = 0;
  logic [7:0] rx_mem [0:4095];
  logic [7:0] mosi_log [$];

  always @(posedge raw_clk) begin
    if (spi_start) begin
      mosi_log.push_back(spi_data_tx);
      n_start <= n_start + 1;
      if (eng_active) dup_start <= dup_start + 1;
    end
    if (!eng_active) begin
      if (spi_start) begin
        eng_active <= 1'b1;
        eng_k      <= 1;
        if (eng_delay == 1) spi_busy <= 1'b1;
      end
    end else begin
      eng_k <= eng_k + 1;
      if (eng_k == eng_delay - 1) spi_busy <= 1'b1;
      if (eng_k == eng_delay - 1 + eng_hold) begin
        spi_busy    <= 1'b0;
        spi_data_rx <= rx_mem[eng_rd % 4096];
        eng_rd      <= eng_rd + 1;
        eng_active  <= 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] got_q [$];
  int n_bv = 0, n_done = 0;
  int last_bv_cyc = 0, done_cyc = 0, fall_cyc = 0, rise_cyc = 0, first_start_cyc = 0;
  bit prev_cs_n = 1'b1;
  bit armed = 1'b0;

  always @(negedge raw_clk) begin
    prev_cs_n <= cs_n;
    if (byte_valid) begin
      got_q.push_back(byte_data);
      n_bv        <= n_bv + 1;
      last_bv_cyc <= cyc;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
    if (prev_cs_n && !cs_n) begin
      fall_cyc <= cyc;
      armed    <= 1'b1;
    end
    if (!prev_cs_n && cs_n) rise_cyc <= cyc;
    if (spi_start && armed) begin
      first_start_cyc <= cyc;
      armed           <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] fixed_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge raw_clk);
    #1;
  endtask

  task automatic fill_rx(input int count);
    for (int i = 0; i < count; i++) rx_mem[(eng_rd + i) % 4096] = 8'($urandom);
  endtask

  task automatic wait_done(input int d0, input int limit, input string tag);
    int budget;
    budget = limit;
    while (n_done == d0 && budget > 0) begin
      tick();
      budget--;
    end
    check({tag, " done seen before timeout"}, 32'(budget > 0), 32'd1);
  endtask

  // One full read, checked against a byte-level model of the flash protocol.
  task automatic run_txn(input logic [23:0] a, input logic [7:0] l, input int dly,
                         input int hld, input int exp_cnt, input string tag);
    int n, base, bv0, d0, st0, mo0, g0, mism, dup0;
    logic [7:0] b;
    logic [7:0] exp_d [$];
    logic [7:0] exp_m [$];
    n = (l == 8'd0) ? 256 : int'(l);
    eng_delay = dly;
    eng_hold  = hld;
    base = eng_rd;
    for (int i = 0; i < n + 4; i++) begin
      if (i >= 4 && fixed_q.size() > 0) b = fixed_q.pop_front();
      else b = 8'($urandom);
      rx_mem[(base + i) % 4096] = b;
      if (i >= 4) exp_d.push_back(b);
    end
    exp_m.push_back(CMD);
    exp_m.push_back(a[23:16]);
    exp_m.push_back(a[15:8]);
    exp_m.push_back(a[7:0]);
    for (int i = 0; i < n; i++) exp_m.push_back(8'h00);
    bv0 = n_bv; d0 = n_done; st0 = n_start; mo0 = mosi_log.size(); g0 = got_q.size();
    dup0 = dup_start;

    address = a; length = l; req = 1'b1;
    tick();
    req = 1'b0; address = 24'($urandom); length = 8'($urandom);
    tick(); tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    wait_done(d0, (n + 4) * (dly + hld + 5) + 60, tag);
    for (int i = 0; i < 5; i++) tick();

    check({tag, " idle after done, stray req ignored"}, 32'(busy), 32'd0);
    check({tag, " byte_valid count"}, n_bv - bv0, exp_cnt);
    check({tag, " byte_valid count vs model"}, n_bv - bv0, n);
    mism = 0;
    for (int i = 0; i < n && (g0 + i) < got_q.size(); i++)
      if (got_q[g0 + i] !== exp_d[i]) mism++;
    check({tag, " data byte mismatches"}, mism, 0);
    check({tag, " done pulses"}, n_done - d0, 1);
    check({tag, " spi_start pulses"}, n_start - st0, n + 4);
    check({tag, " duplicate starts"}, dup_start - dup0, 0);
    check({tag, " mosi byte count"}, mosi_log.size() - mo0, n + 4);
    mism = 0;
    for (int i = 0; i < n + 4 && (mo0 + i) < mosi_log.size(); i++)
      if (mosi_log[mo0 + i] !== exp_m[i]) mism++;
    check({tag, " mosi byte mismatches"}, mism, 0);
    check({tag, " cs_n fall to first start"}, first_start_cyc - fall_cyc, SETUP);
    check({tag, " last byte to cs_n rise"}, rise_cyc - last_bv_cyc, HOLD);
    check({tag, " last byte to done"}, done_cyc - last_bv_cyc, HOLD + 1);
  endtask

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  len;
    int          dly;
    int          hld;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int bv0, d0, budget, seen_hi, bad;

    vecs[0] = '{24'hABCDEF, 8'd1,   1, 2, 1};
    vecs[1] = '{24'h000000, 8'd3,   3, 2, 3};
    vecs[2] = '{24'hFFFFFF, 8'd255, 1, 1, 255};
    vecs[3] = '{24'h123456, 8'd0,   1, 2, 256};
    vecs[4] = '{24'h800001, 8'd5,   3, 5, 5};

    reset = 1'b1; req = 1'b0; address = 24'h000000; length = 8'd0;
    for (int i = 0; i < 3; i++) tick();
    check("reset cs_n", 32'(cs_n), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset spi_start", 32'(spi_start), 32'd0);
    check("reset byte_valid", 32'(byte_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset byte_data", 32'(byte_data), 32'h00);
    check("reset spi_data_tx", 32'(spi_data_tx), 32'h00);
    reset = 1'b0;
    tick();

    // Reference read: address 012345, two bytes A5 3C.
    fixed_q.push_back(8'hA5);
    fixed_q.push_back(8'h3C);
    run_txn(24'h012345, 8'd2, 1, 3, 2, "ref");
    check("ref first data byte", 32'(got_q[got_q.size() - 2]), 32'hA5);
    check("ref second data byte", 32'(got_q[got_q.size() - 1]), 32'h3C);

    for (int i = 0; i < 5; i++)
      run_txn(vecs[i].addr, vecs[i].len, vecs[i].dly, vecs[i].hld, vecs[i].exp_cnt,
              $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      int rl;
      rl = int'($urandom_range(1, 24));
      run_txn(24'($urandom), 8'(rl), int'($urandom_range(1, 3)), int'($urandom_range(1, 6)),
              rl, $sformatf("rnd%0d", i));
    end

    // req held high: second transaction only after done, through IDLE.
    eng_delay = 1; eng_hold = 2;
    fill_rx(64);
    d0 = n_done; bv0 = n_bv;
    address = 24'h00ABCD; length = 8'd3; req = 1'b1;
    wait_done(d0, 400, "held req first");
    check("held req busy low at done", 32'(busy), 32'd0);
    tick();
    check("held req second start", 32'(busy), 32'd1);
    req = 1'b0;
    wait_done(d0 + 1, 400, "held req second");
    check("held req done count", n_done - d0, 2);
    check("held req byte count", n_bv - bv0, 6);
    for (int i = 0; i < 3; i++) tick();

    // Reset while the engine is shifting byte index 5.
    eng_delay = 1; eng_hold = 6;
    fill_rx(64);
    d0 = n_done; bv0 = n_bv;
    address = 24'h246801; length = 8'd8; req = 1'b1;
    tick();
    req = 1'b0;
    budget = 200;
    while (n_bv == bv0 && budget > 0) begin tick(); budget--; end
    budget = 50;
    while (!spi_busy && budget > 0) begin tick(); budget--; end
    check("mid reset reached byte 5", 32'(spi_busy), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check("mid reset cs_n", 32'(cs_n), 32'd1);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset byte_data", 32'(byte_data), 32'h00);
    reset = 1'b0;
    address = 24'h13579B; length = 8'd2; req = 1'b1;
    seen_hi = 0; bad = 0; budget = 40;
    while (spi_busy && budget > 0) begin
      seen_hi = 1;
      if (busy) bad++;
      tick();
      budget--;
    end
    check("engine still busy after reset", seen_hi, 1);
    check("req held off while spi_busy", bad, 0);
    check("no byte_valid after reset", n_bv - bv0, 1);
    check("no done after reset", n_done - d0, 0);
    budget = 5;
    while (!busy && budget > 0) begin tick(); budget--; end
    check("req accepted once spi_busy low", 32'(busy), 32'd1);
    req = 1'b0;
    eng_hold = 2;
    wait_done(d0, 300, "post reset");
    check("post reset byte count", n_bv - bv0, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
